pipe_ctrl: RTL and testbench
============================

# pipe_ctrl

Pipeline controller for the five-stage RISC-V lite core. Sequences the pipeline registers around the `execute` stage by generating register enables, bubble/flush strobes and operand-forwarding selects. Covers load-use stalls, taken-branch flushes, multi-cycle multiply occupancy of EX, and an ecall halt. Sits beside the datapath; all of its outputs drive stage-register `regEn`/flush and the EX operand muxes.

## Interface
- `MUL_LAT`, 4: cycles a multiply occupies EX; legal range ≥2.
- `RW`, 5: register-address width.
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `id_valid`, `id_uses_rs2`  in  1  ID instruction valid; ID reads rs2.
- `id_rs1`, `id_rs2`  in  RW  ID source registers.
- `ex_valid`, `ex_memRead`, `ex_mul`, `ex_ecall`  in  1  EX instruction valid; is a load; is a multiply; is an ecall.
- `ex_rd`, `ex_rs1`, `ex_rs2`  in  RW  EX destination and sources.
- `branch_taken`  in  1  EX branch resolved taken.
- `mem_regWrite`, `wb_regWrite`  in  1  MEM/WB stage writes a register.
- `mem_rd`, `wb_rd`  in  RW  MEM/WB destinations.
- `resume`  in  1  leave HALT.
- `pc_en`, `ifid_en`, `idex_en`, `exmem_en`  out  1  stage-register enables.
- `ifid_flush`, `idex_flush`, `exmem_flush`  out  1  load a bubble into that register.
- `fwdA`, `fwdB`  out  2  EX operand select: 00 regfile, 10 MEM result, 01 WB result.
- `halted`  out  1  high in HALT.
- `stall_cycles`, `flush_events`  out  32  performance counters (see Configuration).

## Operation
- States: RUN, MUL_WAIT, HALT. Down-counter `cnt`, width $clog2(MUL_LAT).
- Default in RUN with no event: all enables 1, all flushes 0.
- RUN priority, highest first:
  - Branch: `ex_valid & branch_taken` → `ifid_flush=1`, `idex_flush=1`, enables 1; stay RUN.
  - Ecall: `ex_valid & ex_ecall` → this cycle normal; next state HALT.
  - Multiply: `ex_valid & ex_mul` → `pc_en=ifid_en=idex_en=0`, `exmem_flush=1`; `cnt<=MUL_LAT-2`; next state MUL_WAIT.
  - Load-use: `ex_valid & ex_memRead & ex_rd!=0 & id_valid & (ex_rd==id_rs1 | id_uses_rs2 & ex_rd==id_rs2)` → `pc_en=ifid_en=0`, `idex_flush=1`; stay RUN.
- MUL_WAIT:
  - `cnt!=0`: same stall as multiply entry; `cnt` decrements.
  - `cnt==0`: all enables 1, flushes 0 (release cycle); next state RUN.
  - Inputs `branch_taken` and `ex_*` are ignored.
  - A multiply immediately following re-enters MUL_WAIT from RUN.
- HALT: all enables 0, flushes 0, `halted=1`. `resume` → RUN next cycle.
- Forwarding, combinational, in all states. `fwdA=10` if `mem_regWrite & mem_rd!=0 & mem_rd==ex_rs1`; else `01` if the same holds for WB; else `00`. MEM wins over WB. `fwdB` is identical, using `ex_rs2`.

## Timing
- Enables, flushes and forwarding are combinational from inputs plus state; no added latency.
- State, `cnt` and counters update on the rising `clk` edge.
- Multiply: EX is held exactly MUL_LAT cycles. Stall cycles are entry plus MUL_LAT-2 in MUL_WAIT, giving MUL_LAT-1 total; the release cycle does not stall.
- Load-use: exactly one stall cycle.
- Branch flush: one cycle.
- Branch and load-use in the same cycle: flush wins, no stall.
- Reset (`rst`=0, asynchronous):
  - State RUN, `cnt` 0, counters 0.
  - While asserted: all enables 0, flushes 0, `fwdA`/`fwdB` 00, `halted` 0.
  - Reset asserted mid-MUL_WAIT or in HALT returns to RUN on release; no pending stall survives.

## Configuration
- `PIPE_CTRL_PERF_EN` defined:
  - `stall_cycles` increments each cycle `pc_en=0` outside reset, including HALT.
  - `flush_events` increments on each branch flush.
  - Both saturate at 32'hFFFFFFFF.
- Undefined: counter logic absent; both ports driven 0.

## Test plan
- Reset then idle, all valids 0: enables 1, flushes 0, `fwdA`/`fwdB` 00, `halted` 0.
- Load-use: `ex_memRead=1`, `ex_rd=11`, `id_rs1=11` → one cycle with `pc_en=0`, `ifid_en=0`, `idex_flush=1`; next cycle all enables 1.
- Multiply with MUL_LAT=4: `ex_mul` pulse → 3 cycles with `pc_en=ifid_en=idex_en=0` and `exmem_flush=1`, then a release cycle; back-to-back multiply → 3 more stall cycles.
- Branch plus load-use in the same cycle → `ifid_flush=idex_flush=1`, `pc_en=1`. With PERF_EN, `flush_events` goes 0→1.
- Forwarding: `ex_rs1=14`, `mem_rd=14`, `wb_rd=14`, both regWrite=1 → `fwdA=10`. With `mem_rd=0` → `fwdA=01`.
- Ecall → HALT: enables 0 and `halted=1` until a `resume` pulse. Asserting `rst` during MUL_WAIT → RUN after reset release, no residual stall.

Source files
------------

// File: rtl/pipe_ctrl.sv
// Pipeline controller: stage enables, bubble/flush strobes and EX forwarding selects.
// Optional performance counters are built only when PIPE_CTRL_PERF_EN is defined.
module pipe_ctrl #(
  parameter int MUL_LAT = 4,
  parameter int RW      = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          id_valid,
  input  logic          id_uses_rs2,
  input  logic [RW-1:0] id_rs1,
  input  logic [RW-1:0] id_rs2,
  input  logic          ex_valid,
  input  logic          ex_memRead,
  input  logic          ex_mul,
  input  logic          ex_ecall,
  input  logic [RW-1:0] ex_rd,
  input  logic [RW-1:0] ex_rs1,
  input  logic [RW-1:0] ex_rs2,
  input  logic          branch_taken,
  input  logic          mem_regWrite,
  input  logic          wb_regWrite,
  input  logic [RW-1:0] mem_rd,
  input  logic [RW-1:0] wb_rd,
  input  logic          resume,
  output logic          pc_en,
  output logic          ifid_en,
  output logic          idex_en,
  output logic          exmem_en,
  output logic          ifid_flush,
  output logic          idex_flush,
  output logic          exmem_flush,
  output logic [1:0]    fwdA,
  output logic [1:0]    fwdB,
  output logic          halted,
  output logic [31:0]   stall_cycles,
  output logic [31:0]   flush_events
);

  // state    | meaning
  // RUN      | normal issue; branch / ecall / multiply / load-use handled here
  // MUL_WAIT | multiply still occupying EX; cnt counts remaining stall cycles
  // HALT     | ecall retired, everything frozen until resume
  typedef enum logic [1:0] {S_RUN, S_MUL_WAIT, S_HALT} state_t;

  localparam int CW = $clog2(MUL_LAT);
  localparam logic [CW-1:0] CNT_INIT = CW'(MUL_LAT - 2);

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;

  logic pc_en_c, ifid_en_c, idex_en_c, exmem_en_c;
  logic ifid_flush_c, idex_flush_c, exmem_flush_c;
  logic halted_c;
  logic load_use;
  logic [1:0] fwd_a_c, fwd_b_c;

  assign load_use = ex_valid && ex_memRead && (ex_rd != '0) && id_valid &&
                    ((ex_rd == id_rs1) || (id_uses_rs2 && (ex_rd == id_rs2)));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_RUN;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    pc_en_c       = 1'b1;
    ifid_en_c     = 1'b1;
    idex_en_c     = 1'b1;
    exmem_en_c    = 1'b1;
    ifid_flush_c  = 1'b0;
    idex_flush_c  = 1'b0;
    exmem_flush_c = 1'b0;
    halted_c      = 1'b0;
    case (state)
      S_RUN: begin
        if (ex_valid && branch_taken) begin
          ifid_flush_c = 1'b1;
          idex_flush_c = 1'b1;
        end else if (ex_valid && ex_ecall) begin
          state_nxt = S_HALT;
        end else if (ex_valid && ex_mul) begin
          pc_en_c       = 1'b0;
          ifid_en_c     = 1'b0;
          idex_en_c     = 1'b0;
          exmem_flush_c = 1'b1;
          cnt_nxt       = CNT_INIT;
          state_nxt     = S_MUL_WAIT;
        end else if (load_use) begin
          pc_en_c      = 1'b0;
          ifid_en_c    = 1'b0;
          idex_flush_c = 1'b1;
        end
      end
      S_MUL_WAIT: begin
        // cnt==0 is the release cycle: EX result moves on, nothing stalls
        if (cnt != '0) begin
          pc_en_c       = 1'b0;
          ifid_en_c     = 1'b0;
          idex_en_c     = 1'b0;
          exmem_flush_c = 1'b1;
          cnt_nxt       = cnt - CW'(1);
        end else begin
          state_nxt = S_RUN;
        end
      end
      S_HALT: begin
        pc_en_c    = 1'b0;
        ifid_en_c  = 1'b0;
        idex_en_c  = 1'b0;
        exmem_en_c = 1'b0;
        halted_c   = 1'b1;
        if (resume) state_nxt = S_RUN;
      end
      default: state_nxt = S_RUN;
    endcase
  end

  always_comb begin
    fwd_a_c = 2'b00;
    if (mem_regWrite && (mem_rd != '0) && (mem_rd == ex_rs1))
      fwd_a_c = 2'b10;
    else if (wb_regWrite && (wb_rd != '0) && (wb_rd == ex_rs1))
      fwd_a_c = 2'b01;
  end

  always_comb begin
    fwd_b_c = 2'b00;
    if (mem_regWrite && (mem_rd != '0) && (mem_rd == ex_rs2))
      fwd_b_c = 2'b10;
    else if (wb_regWrite && (wb_rd != '0) && (wb_rd == ex_rs2))
      fwd_b_c = 2'b01;
  end

  // Reset forces every output quiet so the datapath holds still while in reset.
  assign pc_en       = rst & pc_en_c;
  assign ifid_en     = rst & ifid_en_c;
  assign idex_en     = rst & idex_en_c;
  assign exmem_en    = rst & exmem_en_c;
  assign ifid_flush  = rst & ifid_flush_c;
  assign idex_flush  = rst & idex_flush_c;
  assign exmem_flush = rst & exmem_flush_c;
  assign halted      = rst & halted_c;
  assign fwdA        = rst ? fwd_a_c : 2'b00;
  assign fwdB        = rst ? fwd_b_c : 2'b00;

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_q, flush_q;

  // ifid_flush is only ever raised by a taken branch, so it doubles as the flush event
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (!pc_en_c && (stall_q != 32'hFFFF_FFFF)) stall_q <= stall_q + 32'd1;
      if (ifid_flush_c && (flush_q != 32'hFFFF_FFFF)) flush_q <= flush_q + 32'd1;
    end
  end

  assign stall_cycles = stall_q;
  assign flush_events = flush_q;
`else
  assign stall_cycles = 32'd0;
  assign flush_events = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed scoreboard bench for pipe_ctrl (MUL_LAT=4): the driver pushes hand-computed
// expectations each cycle, a negedge monitor pops and compares them.
module tb_pipe_ctrl;
  localparam int RW = 5;

  logic clk = 1'b0;
  logic rst;
  logic id_valid, id_uses_rs2;
  logic [RW-1:0] id_rs1, id_rs2;
  logic ex_valid, ex_memRead, ex_mul, ex_ecall;
  logic [RW-1:0] ex_rd, ex_rs1, ex_rs2;
  logic branch_taken, mem_regWrite, wb_regWrite;
  logic [RW-1:0] mem_rd, wb_rd;
  logic resume;
  logic pc_en, ifid_en, idex_en, exmem_en;
  logic ifid_flush, idex_flush, exmem_flush;
  logic [1:0] fwdA, fwdB;
  logic halted;
  logic [31:0] stall_cycles, flush_events;

  pipe_ctrl #(.MUL_LAT(4), .RW(RW)) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_uses_rs2(id_uses_rs2), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .ex_valid(ex_valid), .ex_memRead(ex_memRead), .ex_mul(ex_mul), .ex_ecall(ex_ecall),
    .ex_rd(ex_rd), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
    .branch_taken(branch_taken), .mem_regWrite(mem_regWrite), .wb_regWrite(wb_regWrite),
    .mem_rd(mem_rd), .wb_rd(wb_rd), .resume(resume),
    .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush), .exmem_flush(exmem_flush),
    .fwdA(fwdA), .fwdB(fwdB), .halted(halted),
    .stall_cycles(stall_cycles), .flush_events(flush_events)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [3:0]  en;
    logic [2:0]  fl;
    logic [1:0]  fa;
    logic [1:0]  fb;
    logic        h;
    logic [31:0] sc;
    logic [31:0] fe;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int n_vec = 0;
  int n_err = 0;
  int exp_sc = 0;
  int exp_fe = 0;

  always @(negedge clk) begin
    if (q.size() > 0) begin
      e = q.pop_front();
      n_vec++;
      if ({pc_en, ifid_en, idex_en, exmem_en} !== e.en ||
          {ifid_flush, idex_flush, exmem_flush} !== e.fl ||
          fwdA !== e.fa || fwdB !== e.fb || halted !== e.h ||
          stall_cycles !== e.sc || flush_events !== e.fe) begin
        n_err++;
        $display("FAIL %s: got en=%b fl=%b fwdA=%b fwdB=%b halted=%b stall=%0d flush=%0d, want en=%b fl=%b fwdA=%b fwdB=%b halted=%b stall=%0d flush=%0d",
                 e.name, {pc_en, ifid_en, idex_en, exmem_en}, {ifid_flush, idex_flush, exmem_flush},
                 fwdA, fwdB, halted, stall_cycles, flush_events,
                 e.en, e.fl, e.fa, e.fb, e.h, e.sc, e.fe);
      end
    end
  end

  task automatic idle();
    id_valid = 0; id_uses_rs2 = 0; id_rs1 = 0; id_rs2 = 0;
    ex_valid = 0; ex_memRead = 0; ex_mul = 0; ex_ecall = 0;
    ex_rd = 0; ex_rs1 = 0; ex_rs2 = 0;
    branch_taken = 0; mem_regWrite = 0; wb_regWrite = 0;
    mem_rd = 0; wb_rd = 0; resume = 0;
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
    idle();
  endtask

  // en = {pc,ifid,idex,exmem}; fl = {ifid,idex,exmem}; counter expectations advance after each cycle
  task automatic chk(input string nm, input logic [3:0] en, input logic [2:0] fl,
                     input logic [1:0] fa, input logic [1:0] fb, input logic h);
    exp_t x;
    if (!rst) begin
      exp_sc = 0;
      exp_fe = 0;
    end
    x.name = nm; x.en = en; x.fl = fl; x.fa = fa; x.fb = fb; x.h = h;
`ifdef PIPE_CTRL_PERF_EN
    x.sc = 32'(exp_sc);
    x.fe = 32'(exp_fe);
`else
    x.sc = 32'd0;
    x.fe = 32'd0;
`endif
    q.push_back(x);
    if (rst && !en[3]) exp_sc++;
    if (rst && fl[2]) exp_fe++;
  endtask

  initial begin
    rst = 1'b0;
    idle();
    @(posedge clk); #1;
    ex_rs1 = 14; mem_rd = 14; mem_regWrite = 1;
    chk("reset_quiet", 4'b0000, 3'b000, 2'b00, 2'b00, 0);

    nxt(); rst = 1'b1;
    chk("idle_after_reset", 4'b1111, 3'b000, 2'b00, 2'b00, 0);

    nxt(); ex_valid = 1; ex_memRead = 1; ex_rd = 11; id_valid = 1; id_rs1 = 11;
    chk("load_use_rs1", 4'b0011, 3'b010, 2'b00, 2'b00, 0);
    nxt();
    chk("load_use_done", 4'b1111, 3'b000, 2'b00, 2'b00, 0);
    nxt(); ex_valid = 1; ex_memRead = 1; ex_rd = 7; id_valid = 1; id_rs2 = 7;
    chk("rs2_not_used", 4'b1111, 3'b000, 2'b00, 2'b00, 0);
    nxt(); ex_valid = 1; ex_memRead = 1; ex_rd = 7; id_valid = 1; id_rs2 = 7; id_uses_rs2 = 1;
    chk("load_use_rs2", 4'b0011, 3'b010, 2'b00, 2'b00, 0);
    nxt(); ex_valid = 1; ex_memRead = 1; ex_rd = 0; id_valid = 1; id_rs1 = 0;
    chk("load_x0_no_stall", 4'b1111, 3'b000, 2'b00, 2'b00, 0);

    nxt(); ex_valid = 1; ex_mul = 1;
    chk("mul_entry", 4'b0001, 3'b001, 2'b00, 2'b00, 0);
    nxt(); ex_valid = 1; branch_taken = 1;
    chk("mul_wait1_ignores_branch", 4'b0001, 3'b001, 2'b00, 2'b00, 0);
    nxt();
    chk("mul_wait2", 4'b0001, 3'b001, 2'b00, 2'b00, 0);
    nxt();
    chk("mul_release", 4'b1111, 3'b000, 2'b00, 2'b00, 0);
    nxt(); ex_valid = 1; ex_mul = 1;
    chk("mul2_entry", 4'b0001, 3'b001, 2'b00, 2'b00, 0);
    nxt();
    chk("mul2_wait1", 4'b0001, 3'b001, 2'b00, 2'b00, 0);
    nxt();
    chk("mul2_wait2", 4'b0001, 3'b001, 2'b00, 2'b00, 0);
    nxt();
    chk("mul2_release", 4'b1111, 3'b000, 2'b00, 2'b00, 0);

    nxt(); ex_valid = 1; branch_taken = 1; ex_memRead = 1; ex_rd = 5; id_valid = 1; id_rs1 = 5;
    chk("branch_beats_load_use", 4'b1111, 3'b110, 2'b00, 2'b00, 0);
    nxt();
    chk("after_branch", 4'b1111, 3'b000, 2'b00, 2'b00, 0);

    nxt(); ex_rs1 = 14; mem_rd = 14; wb_rd = 14; mem_regWrite = 1; wb_regWrite = 1;
    chk("fwdA_mem_wins", 4'b1111, 3'b000, 2'b10, 2'b00, 0);
    nxt(); ex_rs1 = 14; mem_rd = 0; wb_rd = 14; mem_regWrite = 1; wb_regWrite = 1;
    chk("fwdA_wb", 4'b1111, 3'b000, 2'b01, 2'b00, 0);
    nxt(); ex_rs2 = 3; mem_rd = 3; wb_rd = 3; wb_regWrite = 1;
    chk("fwdB_wb_mem_nowrite", 4'b1111, 3'b000, 2'b00, 2'b01, 0);
    nxt(); ex_rs1 = 9; ex_rs2 = 9; mem_rd = 9; mem_regWrite = 1;
    chk("fwdAB_mem", 4'b1111, 3'b000, 2'b10, 2'b10, 0);
    nxt(); ex_rs1 = 0; wb_rd = 0; wb_regWrite = 1;
    chk("fwd_x0_none", 4'b1111, 3'b000, 2'b00, 2'b00, 0);

    nxt(); ex_valid = 1; ex_ecall = 1; ex_memRead = 1; ex_rd = 6; id_valid = 1; id_rs1 = 6;
    chk("ecall_cycle_normal", 4'b1111, 3'b000, 2'b00, 2'b00, 0);
    nxt(); ex_valid = 1; ex_mul = 1;
    chk("halt1", 4'b0000, 3'b000, 2'b00, 2'b00, 1);
    nxt(); ex_rs2 = 4; wb_rd = 4; wb_regWrite = 1;
    chk("halt2_fwd_live", 4'b0000, 3'b000, 2'b00, 2'b01, 1);
    nxt(); resume = 1;
    chk("halt_resume_cycle", 4'b0000, 3'b000, 2'b00, 2'b00, 1);
    nxt();
    chk("run_after_resume", 4'b1111, 3'b000, 2'b00, 2'b00, 0);

    nxt(); ex_valid = 1; ex_mul = 1;
    chk("mul3_entry", 4'b0001, 3'b001, 2'b00, 2'b00, 0);
    nxt();
    chk("mul3_wait1", 4'b0001, 3'b001, 2'b00, 2'b00, 0);
    nxt(); rst = 1'b0;
    chk("reset_mid_mul", 4'b0000, 3'b000, 2'b00, 2'b00, 0);
    nxt(); rst = 1'b1;
    chk("no_residual_stall", 4'b1111, 3'b000, 2'b00, 2'b00, 0);
    nxt();
    chk("idle_end", 4'b1111, 3'b000, 2'b00, 2'b00, 0);

    for (int i = 0; i < 4 && q.size() > 0; i++) @(negedge clk);
    #1;
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d pending, want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
